// File: rtl/proc_ctrl.sv
// proc_ctrl: multicycle control sequencer for a 16-bit register/ALU/bus datapath.
// Ports: Clock, Resetn (async, active-low), Run, DIN -> Rin/Rout/DINout/Gout/Ain/Gin/alu_op/Done.
module proc_ctrl #(
    parameter int DW = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic [7:0]    Rin,
    output logic [7:0]    Rout,
    output logic          DINout,
    output logic          Gout,
    output logic          Ain,
    output logic          Gin,
    output logic [2:0]    alu_op,
    output logic          Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b110;
    localparam logic [2:0] OP_MVI = 3'b111;

    state_t     state_q, state_d;
    logic [8:0] ir_q, ir_d;
    logic [2:0] op, rx, ry;
    logic [7:0] x_hot, y_hot;
    logic       ir_load;
    logic       unused_din;

    assign op    = ir_q[8:6];
    assign rx    = ir_q[5:3];
    assign ry    = ir_q[2:0];
    assign x_hot = 8'd1 << rx;
    assign y_hot = 8'd1 << ry;

    // Only the top nine bits of DIN carry the instruction.
    assign unused_din = ^DIN[DW-10:0];

    // Fetch enable, also held off while reset is asserted.
    assign ir_load = Resetn && Run && (state_q == T0);
    assign ir_d    = ir_load ? DIN[DW-1:DW-9] : ir_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs decode from state and IR only, so an asynchronous reset
    // returns them to zero in the same instant the state drops to T0.
    always_comb begin
        state_d = state_q;
        Rin     = '0;
        Rout    = '0;
        DINout  = 1'b0;
        Gout    = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        alu_op  = 3'b000;
        Done    = 1'b0;
        unique case (state_q)
            T0: begin
                if (Run) state_d = T1;
            end
            T1: begin
                if (op == OP_MV) begin
                    Rout    = y_hot;
                    Rin     = x_hot;
                    Done    = 1'b1;
                    state_d = T0;
                end else if (op == OP_MVI) begin
                    DINout  = 1'b1;
                    Rin     = x_hot;
                    Done    = 1'b1;
                    state_d = T0;
                end else begin
                    Rout    = x_hot;
                    Ain     = 1'b1;
                    state_d = T2;
                end
            end
            T2: begin
                Rout    = y_hot;
                Gin     = 1'b1;
                alu_op  = op;
                state_d = T3;
            end
            T3: begin
                Gout    = 1'b1;
                Rin     = x_hot;
                Done    = 1'b1;
                state_d = T0;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: directed + random bench for proc_ctrl with an attached
// datapath and an instruction-level register model.
module tb_proc_ctrl;

    localparam int DW = 16;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic       dinout;
        logic       gout;
        logic       ain;
        logic       gin;
        logic [2:0] op;
        logic       done;
    } ctl_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [DW-1:0] din = '0;
    logic [7:0]    rin, rout;
    logic          dinout, gout, ain, gin, done;
    logic [2:0]    alu_op;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_done_cyc;

    ctl_t        sched[$];
    logic [15:0] ref_r[8];

    logic [15:0] dp_r[8];
    logic [15:0] dp_a, dp_g, bus;

    logic watch = 1'b0;
    logic saw7 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    proc_ctrl #(.DW(DW)) dut (
        .Clock (clk),
        .Resetn(rst_n),
        .Run   (run),
        .DIN   (din),
        .Rin   (rin),
        .Rout  (rout),
        .DINout(dinout),
        .Gout  (gout),
        .Ain   (ain),
        .Gin   (gin),
        .alu_op(alu_op),
        .Done  (done)
    );

    function automatic logic [15:0] alu(input logic [2:0] f,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return (a < b) ? 16'd1 : 16'd0;
            3'd4:    return a << b[3:0];
            3'd5:    return a >> b[3:0];
            default: return 16'd0;
        endcase
    endfunction

    // Datapath driven purely by the controller outputs.
    always_comb begin
        bus = '0;
        if (dinout) bus = din;
        else if (gout) bus = dp_g;
        else
            for (int i = 0; i < 8; i++)
                if (rout[i]) bus = dp_r[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (rin[i]) dp_r[i] <= bus;
        if (ain) dp_a <= bus;
        if (gin) dp_g <= alu(alu_op, dp_a, bus);
    end

    always @(rin or watch)
        if (watch && rin[7]) saw7 = 1'b1;

    function automatic ctl_t obs();
        return {rin, rout, dinout, gout, ain, gin, alu_op, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic cyc_chk(input string tag, input ctl_t e);
        int srcs;
        srcs = $countones(rout) + int'(dinout) + int'(gout);
        chk(tag, 32'(obs()), 32'(e));
        chk({tag, "/inv"},
            {29'd0, $onehot0(rin), $onehot0(rout), srcs <= 1},
            32'd7);
    endtask

    // Expected per-timestep controls after the fetch, straight from the
    // instruction's register-transfer description.
    task automatic build(input logic [2:0] op, input logic [2:0] x,
                         input logic [2:0] y);
        ctl_t c;
        sched.delete();
        if (op == 3'b110) begin
            c = '0; c.rout = 8'd1 << y; c.rin = 8'd1 << x; c.done = 1'b1;
            sched.push_back(c);
        end else if (op == 3'b111) begin
            c = '0; c.dinout = 1'b1; c.rin = 8'd1 << x; c.done = 1'b1;
            sched.push_back(c);
        end else begin
            c = '0; c.rout = 8'd1 << x; c.ain = 1'b1;
            sched.push_back(c);
            c = '0; c.rout = 8'd1 << y; c.gin = 1'b1; c.op = op;
            sched.push_back(c);
            c = '0; c.gout = 1'b1; c.rin = 8'd1 << x; c.done = 1'b1;
            sched.push_back(c);
        end
    endtask

    // Entered and left at a falling edge while the controller sits in T0.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] x,
                             input logic [2:0] y, input logic [15:0] imm,
                             input bit hold);
        int lat;
        string tag;
        cyc_chk("t0", '0);
        build(op, x, y);
        run = 1'b1;
        din = {op, x, y, 7'($urandom)};
        lat = 1;
        for (int k = 0; k < sched.size(); k++) begin
            @(negedge clk);
            lat++;
            tag = $sformatf("op%0d x%0d y%0d t%0d", op, x, y, k + 1);
            cyc_chk(tag, sched[k]);
            if (sched[k].done) last_done_cyc = cyc;
            run = hold ? 1'b1 : 1'($urandom);
            din = (op == 3'b111 && k == 0) ? imm : 16'($urandom);
        end
        chk("latency", lat, (op[2:1] == 2'b11) ? 2 : 4);
        case (op)
            3'b110:  ref_r[x] = ref_r[y];
            3'b111:  ref_r[x] = imm;
            default: ref_r[x] = alu(op, ref_r[x], ref_r[y]);
        endcase
        @(negedge clk);
        chk($sformatf("R%0d", x), dp_r[x], ref_r[x]);
    endtask

    task automatic alu_case(input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] e);
        run_instr(3'b111, 3'd2, 3'd0, a, 1'b0);
        run_instr(3'b111, 3'd3, 3'd0, b, 1'b0);
        run_instr(op, 3'd2, 3'd3, 16'd0, 1'b0);
        chk($sformatf("alu%0d result", op), dp_r[2], e);
    endtask

    initial begin
        int c0;
        logic [2:0] rop;

        // Reset held with Run high and an all-ones DIN.
        rst_n = 1'b0;
        run   = 1'b1;
        din   = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            cyc_chk("reset", '0);
        end
        rst_n = 1'b1;
        run_instr(3'b111, 3'd7, 3'd7, 16'h1234, 1'b1);

        // Idle T0 with Run low.
        run = 1'b0;
        repeat (3) begin
            @(negedge clk);
            cyc_chk("idle", '0);
        end

        for (int i = 0; i < 7; i++)
            run_instr(3'b111, 3'(i), 3'($urandom), 16'($urandom), 1'b0);

        run_instr(3'b111, 3'd1, 3'd0, 16'h00A5, 1'b0);
        chk("mvi R1", dp_r[1], 16'h00A5);

        run_instr(3'b111, 3'd0, 3'd0, 16'd5, 1'b0);
        run_instr(3'b111, 3'd1, 3'd0, 16'd7, 1'b0);
        run_instr(3'b000, 3'd0, 3'd1, 16'd0, 1'b0);
        chk("add R0", dp_r[0], 16'd12);

        alu_case(3'b001, 16'd9, 16'd4, 16'd5);
        alu_case(3'b010, 16'h0F0, 16'h00F, 16'h0FF);
        alu_case(3'b011, 16'd3, 16'd8, 16'd1);
        alu_case(3'b011, 16'd8, 16'd3, 16'd0);
        alu_case(3'b100, 16'd1, 16'd4, 16'd16);
        alu_case(3'b101, 16'h80, 16'd3, 16'h10);

        run_instr(3'b111, 3'd3, 3'd0, 16'd21, 1'b0);
        run_instr(3'b000, 3'd3, 3'd3, 16'd0, 1'b0);
        chk("add R3,R3", dp_r[3], 16'd42);
        run_instr(3'b110, 3'd2, 3'd2, 16'd0, 1'b0);

        // Back-to-back with Run held high.
        c0 = cyc;
        run_instr(3'b110, 3'd4, 3'd6, 16'd0, 1'b1);
        chk("b2b done1", last_done_cyc - c0 + 1, 2);
        run_instr(3'b001, 3'd4, 3'd5, 16'd0, 1'b1);
        chk("b2b done2", last_done_cyc - c0 + 1, 6);

        // Reset during T2 of add R7,R0.
        build(3'b000, 3'd7, 3'd0);
        cyc_chk("pre-abort t0", '0);
        run = 1'b1;
        din = {3'b000, 3'd7, 3'd0, 7'd0};
        @(negedge clk);
        watch = 1'b1;
        cyc_chk("abort t1", sched[0]);
        run = 1'b0;
        @(negedge clk);
        cyc_chk("abort t2", sched[1]);
        #2 rst_n = 1'b0;
        #1 cyc_chk("abort async", '0);
        @(negedge clk);
        cyc_chk("abort held", '0);
        chk("abort no Rin7", saw7, 1'b0);
        chk("abort R7", dp_r[7], ref_r[7]);
        rst_n = 1'b1;
        watch = 1'b0;
        run_instr(3'b110, 3'd7, 3'd1, 16'd0, 1'b0);

        // Random instruction stream against the register model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'b110 && $urandom_range(0, 1) == 0) rop = 3'b111;
            run_instr(rop, 3'($urandom), 3'($urandom), 16'($urandom),
                      1'($urandom));
        end

        for (int i = 0; i < 8; i++)
            chk($sformatf("final R%0d", i), dp_r[i], ref_r[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Multicycle control sequencer for the 16-bit datapath: register file R0..R7, A register, ALU, G register and a shared Bus.
- Fetches an instruction word from DIN when Run is asserted and steps through up to four timesteps (T0..T3).
- Per cycle, drives the register enables, the single Bus source select, the 3-bit ALU operation code, and Done.
- Is the producer of the ALU's control field. Its op encoding is the ALU's: add 000, sub 001, or 010, slt 011, sll 100, srl 101. Codes 110 (mv) and 111 (mvi) are handled without the ALU.

Parameters:
- DW, 16, width of DIN; the instruction fields are taken from DIN[DW-1:DW-9].

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request; sampled only in T0.
- DIN  in  DW  instruction/immediate input. Field layout: opcode = DIN[15:13], X = DIN[12:10], Y = DIN[9:7]; low bits are ignored.
- Rin  out  8  one-hot register-file write enable, Rin[i] loads Ri from Bus.
- Rout  out  8  one-hot select for Ri onto Bus.
- DINout  out  1  DIN onto Bus.
- Gout  out  1  G onto Bus.
- Ain  out  1  load A from Bus.
- Gin  out  1  load G from the ALU result.
- alu_op  out  3  ALU control code.
- Done  out  1  instruction completes this cycle.

Behaviour:
- Reset and clock: one clock; Resetn is asynchronous, active-low.
- Resetn=0, asynchronously:
  - state <= T0;
  - IR (9-bit internal: opcode, X, Y) <= 0;
  - all outputs forced to 0, including the Run-qualified T0 enable.
- State register: T0, T1, T2, T3, updated on the rising Clock edge.
- Outputs are combinational from state and IR. Outside the asserted terms listed below, every output is 0 and alu_op = 000.
- T0:
  - IR <= DIN[15:7] when Run=1.
  - Next state T1 if Run=1, else stay in T0.
  - No Bus source driven; Done=0.
- mv (110):
  - T1: Rout[Y]=1, Rin[X]=1, Done=1; next T0.
  - Latency: 2 cycles from the Run sample.
- mvi (111):
  - T1: DINout=1, Rin[X]=1, Done=1; next T0.
  - The immediate is the full DIN word present during T1; the testbench supplies it after the instruction word.
- ALU ops (000..101):
  - T1: Rout[X]=1, Ain=1; next T2.
  - T2: Rout[Y]=1, Gin=1, alu_op=opcode; next T3.
  - T3: Gout=1, Rin[X]=1, Done=1; next T0.
  - Latency: 4 cycles from the Run sample.
- Invariants, checkable every cycle:
  - At most one Bus source is asserted (Rout bits, DINout, Gout).
  - Rin and Rout are each zero or one-hot.
  - Done is high for exactly one cycle per instruction.
  - alu_op is non-zero only in T2.
- X == Y: legal. For example, add R3,R3 doubles R3; mv R2,R2 is a no-op write.
- Run held high continuously: the next instruction is fetched in the T0 that directly follows Done. There is no idle gap beyond the single T0 cycle.
- Run toggled in T1..T3: ignored; the instruction in flight is unaffected.
- DIN changes in T1..T3: IR is unaffected. Only mvi consumes DIN after T0, and only in T1.
- Reset mid-instruction: the sequence aborts immediately. No Rin is asserted after Resetn falls, so there is no partial write-back. The block restarts in T0 after Resetn rises.
- Implementation must not latch: all combinational outputs have defaults.

Test Plan:
1. Reset: hold Resetn=0 with Run=1 and DIN=16'hFFFF -> all outputs 0 and state stays T0. Release Resetn -> IRin-driven fetch occurs on the next edge.
2. mvi: DIN=111_001_000 in T0, then DIN=16'h00A5 in T1 -> T1 drives DINout=1, Rin=8'b0000_0010, Done=1. Back in T0 next cycle.
3. add R0,R1 (000_000_001):
   - T1: Rout=00000001, Ain=1.
   - T2: Rout=00000010, Gin=1, alu_op=000.
   - T3: Gout=1, Rin=00000001, Done=1.
   - With the datapath attached, R0=5 and R1=7 give R0=12.
4. All ALU codes: sweep 001..101 with X=2, Y=3 -> alu_op equals the opcode only in T2. Datapath checks: sub 9-4=5; or 0x0F0|0x00F=0x0FF; slt 3<8 gives 1 and 8<3 gives 0; sll 1<<4=16; srl 0x80>>3=0x10.
5. Back-to-back: Run held high across mv R4,R6 then sub R4,R5 -> Done at cycles 2 and 6 after the first Run sample. Run pulsed in T2 has no effect.
6. Reset mid-op: assert Resetn=0 during T2 of add R7,R0 -> outputs drop to 0 immediately, Rin[7] is never asserted, and the next fetch starts from T0.
